// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared constants, frame-result encoding and frame evaluator
//             for the 4x4 matrix keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_SINGLE = 2'd1;
    localparam logic [1:0] RES_MULTI  = 2'd2;

    localparam logic [NUM_COLS-1:0] COL_SEL_RST = 4'b1110;

    // code is forced to zero unless kind is RES_SINGLE, so whole-struct
    // equality is a valid "same frame result" test.
    typedef struct packed {
        logic [1:0]        kind;
        logic [CODE_W-1:0] code;
    } frame_res_t;

    localparam frame_res_t FRAME_NONE = '{kind: RES_NONE, code: '0};

    // hits bit index is {row_idx, col_idx}, i.e. the key code itself.
    function automatic frame_res_t eval_frame(input logic [NUM_KEYS-1:0] hits);
        frame_res_t res;
        logic [1:0] n;
        res = FRAME_NONE;
        n   = 2'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (hits[i]) begin
                if (n == 2'd0) begin
                    res.code = CODE_W'(i);
                end
                if (n != 2'd2) begin
                    n = n + 2'd1;
                end
            end
        end
        if (n == 2'd1) begin
            res.kind = RES_SINGLE;
        end else if (n == 2'd2) begin
            res.kind = RES_MULTI;
            res.code = '0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for asynchronous level inputs, resets
//             to all-ones (idle level of pulled-up keypad rows).
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Column-multiplexed 4x4 keypad scanner with per-frame debounce,
//             one key_valid pulse per accepted press.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_sel,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int               SLOT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        C_DEB       = 4'(DEBOUNCE_FRAMES);

    logic [NUM_ROWS-1:0]                w_rows_sync;
    logic [SLOT_W-1:0]                  r_slot_cnt;
    logic                               w_slot_wrap;
    logic [1:0]                         r_col_idx;
    logic [NUM_COLS-1:0]                r_col_sel;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]  r_hits;
    logic                               r_frame_done;

    frame_res_t w_res;
    frame_res_t r_cand;
    frame_res_t r_stable;
    frame_res_t r_accept_res;
    frame_res_t w_cand_next;
    logic [3:0] r_match;
    logic [3:0] w_match_next;
    logic       w_accept;
    logic       r_accept;

    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_key_held;

    sync_2ff #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (w_rows_sync)
    );

    assign w_slot_wrap = (r_slot_cnt == C_SLOT_LAST);

    // The sample on the wrap edge belongs to the outgoing column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt   <= '0;
            r_col_idx    <= 2'd0;
            r_col_sel    <= COL_SEL_RST;
            r_hits       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    r_hits[r][r_col_idx] <= ~w_rows_sync[r];
                end
                r_col_idx    <= r_col_idx + 2'd1;
                r_col_sel    <= {r_col_sel[NUM_COLS-2:0], r_col_sel[NUM_COLS-1]};
                r_frame_done <= (r_col_idx == 2'd3);
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end
        end
    end

    assign w_res = eval_frame(r_hits);

    always_comb begin
        w_cand_next  = r_cand;
        w_match_next = r_match;
        w_accept     = 1'b0;
        if (r_frame_done) begin
            if (w_res.kind == RES_MULTI) begin
                w_cand_next  = w_res;
                w_match_next = 4'd0;
            end else if (w_res == r_cand) begin
                if (r_match != C_DEB) begin
                    w_match_next = r_match + 4'd1;
                end
            end else begin
                w_cand_next  = w_res;
                w_match_next = 4'd1;
            end
            // MULTI keeps the count at zero, so it can never be accepted.
            w_accept = (w_match_next == C_DEB) && (w_cand_next != r_stable);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand       <= FRAME_NONE;
            r_match      <= 4'd0;
            r_stable     <= FRAME_NONE;
            r_accept     <= 1'b0;
            r_accept_res <= FRAME_NONE;
        end else begin
            r_cand   <= w_cand_next;
            r_match  <= w_match_next;
            r_accept <= w_accept;
            if (w_accept) begin
                r_stable     <= w_cand_next;
                r_accept_res <= w_cand_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_accept) begin
                if (r_accept_res.kind == RES_SINGLE) begin
                    r_key_code  <= r_accept_res.code;
                    r_key_valid <= 1'b1;
                    r_key_held  <= 1'b1;
                end else begin
                    r_key_held  <= 1'b0;
                end
            end
        end
    end

    assign col_sel   = r_col_sel;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner with a behavioural
//             keypad matrix (key_mask bit {row,col} shorts row to column).
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_sel;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_mask;

    int n_tests;
    int n_fail;
    int pulses;
    int held_low_cnt;
    int edge_cnt;
    int last_pulse_edge;

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic        exp_held;
        logic        exp_dropped;
    } vec_t;

    vec_t vecs [9];

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_sel   (col_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(key_mask[r*4 +: 4] & ~col_sel);
        end
    end

    // edge_cnt = number of rising edges since reset release.
    always @(posedge clk) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            pulses          = pulses + 1;
            last_pulse_edge = edge_cnt;
        end
        if (!key_held) held_low_cnt = held_low_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] mask);
        rst_n    = 1'b0;
        key_mask = mask;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int  p0;
        bit  got;
        p0  = pulses;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick(1);
            if (pulses != p0) got = 1'b1;
        end
        check({name, " arrived"}, 32'(got), 32'd1);
    endtask

    initial begin
        int p0;
        int h0;
        n_tests      = 0;
        n_fail       = 0;
        pulses       = 0;
        held_low_cnt = 0;
        last_pulse_edge = 0;
        key_mask     = 16'h0000;
        rst_n        = 1'b0;

        // pressed mask, frames, pulses, final code, final held, held seen low
        vecs[0] = '{16'h0000, 20, 0, 4'h0, 1'b0, 1'b1};  // idle
        vecs[1] = '{16'h0200,  5, 1, 4'h9, 1'b1, 1'b1};  // row2/col1
        vecs[2] = '{16'h0000,  5, 0, 4'h9, 1'b0, 1'b1};  // release, code kept
        vecs[3] = '{16'h4010,  6, 0, 4'h9, 1'b0, 1'b1};  // two keys -> MULTI
        vecs[4] = '{16'h0010,  5, 1, 4'h4, 1'b1, 1'b1};  // drop to row1/col0
        vecs[5] = '{16'h0020,  5, 1, 4'h5, 1'b1, 1'b0};  // roll-over to 0101
        vecs[6] = '{16'h8000,  5, 1, 4'hF, 1'b1, 1'b0};  // roll-over to 1111
        vecs[7] = '{16'h8000,  6, 0, 4'hF, 1'b1, 1'b0};  // held, no repeat
        vecs[8] = '{16'h0000,  5, 0, 4'hF, 1'b0, 1'b1};  // release

        // reset values
        tick(3);
        check("rst col_sel",   32'(col_sel),   32'hE);
        check("rst key_code",  32'(key_code),  32'h0);
        check("rst key_valid", 32'(key_valid), 32'h0);
        check("rst key_held",  32'(key_held),  32'h0);
        rst_n = 1'b1;

        // column walk: wrap on the 8th edge of each slot
        tick(7);
        check("walk e7",  32'(col_sel), 32'hE);
        tick(1);
        check("walk e8",  32'(col_sel), 32'hD);
        tick(8);
        check("walk e16", 32'(col_sel), 32'hB);
        tick(8);
        check("walk e24", 32'(col_sel), 32'h7);
        tick(8);
        check("walk e32", 32'(col_sel), 32'hE);

        for (int i = 0; i < 9; i++) begin
            key_mask = vecs[i].mask;
            p0 = pulses;
            h0 = held_low_cnt;
            tick(FRAME * vecs[i].frames);
            check($sformatf("v%0d pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d code", i), 32'(key_code), 32'(vecs[i].exp_code));
            check($sformatf("v%0d held", i), 32'(key_held), 32'(vecs[i].exp_held));
            check($sformatf("v%0d held_low_seen", i), 32'(held_low_cnt != h0),
                  32'(vecs[i].exp_dropped));
        end

        // Exact latency from reset release with row2/col1 pressed:
        // col3 samples at edges 32/64/96, count reaches 3 at 97, pulse at 98.
        do_reset(16'h0200);
        wait_pulse("latency", 150);
        check("latency edge", 32'(last_pulse_edge), 32'd98);
        check("latency code", 32'(key_code), 32'h9);
        check("latency held", 32'(key_held), 32'h1);
        tick(1);
        check("pulse width",  32'(key_valid), 32'h0);

        // Reset during the second debounce frame of a new key (0110).
        key_mask = 16'h0040;
        tick(50);
        rst_n = 1'b0;
        #1;
        check("midrst col_sel",   32'(col_sel),   32'hE);
        check("midrst key_code",  32'(key_code),  32'h0);
        check("midrst key_valid", 32'(key_valid), 32'h0);
        check("midrst key_held",  32'(key_held),  32'h0);
        tick(3);
        rst_n = 1'b1;
        p0 = pulses;
        wait_pulse("redebounce", 150);
        check("redebounce edge", 32'(last_pulse_edge), 32'd98);
        check("redebounce code", 32'(key_code), 32'h6);
        tick(2 * FRAME);
        check("redebounce count", 32'(pulses - p0), 32'd1);

        // Bounce on row0/col3, 5-cycle toggles: col3 frames see N,P,P,N,
        // then clean from edge 130 -> frames 160,192,224 -> pulse at 226.
        do_reset(16'h0000);
        p0 = pulses;
        for (int i = 0; i < 26; i++) begin
            key_mask = (i % 2 == 0) ? 16'h0008 : 16'h0000;
            tick(5);
        end
        key_mask = 16'h0008;
        check("bounce no pulse", 32'(pulses - p0), 32'd0);
        wait_pulse("bounce", 150);
        check("bounce edge", 32'(last_pulse_edge), 32'd226);
        check("bounce code", 32'(key_code), 32'h3);
        check("bounce held", 32'(key_held), 32'h1);
        tick(2 * FRAME);
        check("bounce count", 32'(pulses - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Multiplexed 4x4 matrix-keypad scanner for the Elbert V2 board; the input-side counterpart of the multiplexed seven-segment digit driver. Drives one keypad column low at a time, samples the active-low row lines, debounces per full scan frame and reports one 4-bit key code per press. Codes feed directly into the display digit inputs or control logic.

## Interface
- SCAN_DIV, 1000: clk cycles per column slot; legal range >= 8.
- DEBOUNCE_FRAMES, 4: consecutive identical frames required to accept a press or a release; legal range 1..15.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col_sel  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-cycle pulse when key_code updates.
- key_held  output  1  high while an accepted key stays pressed.

## Operation
- Reset values: col_sel=4'b1110, key_code=0, key_valid=0, key_held=0, slot counter=0, column index=0, candidate=NONE, stable=NONE, match count=0.
- row_in passes through a 2-flop synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1:
  - sample the synchronized rows into the frame accumulator for the current column,
  - advance the column index modulo 4 (3 wraps to 0) and rotate col_sel on the same edge.
- Frame: four slots, columns 0,1,2,3. Frame result, evaluated after the column-3 sample:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: two or more intersections low. MULTI is never accepted. It clears the match count and sets candidate=MULTI.
- Debounce:
  - If the frame result equals candidate, the match count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise candidate takes the frame result and the match count becomes 1.
  - Acceptance happens when the match count reaches DEBOUNCE_FRAMES on this frame and candidate differs from stable.
- On acceptance:
  - candidate SINGLE(c): stable=c, key_code=c, key_valid pulses, key_held=1. This applies even when stable was a different key (direct roll-over A->B gives a second pulse).
  - candidate NONE: stable=NONE, key_held=0, no pulse, key_code retained.
- A held key never re-pulses; no auto-repeat.
- Reset asserted mid-frame or mid-debounce returns every register to its reset value immediately. No key_valid is produced by reset.

## Timing
- Column period: SCAN_DIV cycles. Frame period: 4*SCAN_DIV cycles.
- col_sel changes on the clk edge where the slot counter wraps. The sample taken on that same edge belongs to the outgoing column, so rows have had SCAN_DIV-1 cycles to settle.
- Frame result and debounce update happen on the cycle after the column-3 sample edge.
- key_valid and key_code update one cycle after that debounce update, i.e. 2 cycles after the column-3 sample edge. key_valid is high for exactly 1 cycle.
- Minimum press-to-pulse time: DEBOUNCE_FRAMES frames plus 4 cycles (2 synchronizer, 2 pipeline). Maximum: DEBOUNCE_FRAMES+1 frames plus 4 cycles.
- key_held falls 2 cycles after the frame that accepts the release.

## Structure
- Shared package keypad_pkg holds:
  - NUM_ROWS=4, NUM_COLS=4, CODE_W=4,
  - frame-result encoding RES_NONE, RES_SINGLE, RES_MULTI,
  - col_sel reset pattern 4'b1110.
- Sub-module sync_2ff (WIDTH parameter, clk/rst_n, reset value all-ones) synchronizes row_in. All other logic lives in keypad_scanner: slot counter, column rotator, frame accumulator, debounce FSM.

## Test plan
(Bench uses SCAN_DIV=8, DEBOUNCE_FRAMES=3.)
- Reset, no keys: col_sel walks 1110->1101->1011->0111->1110 every 8 cycles. key_valid stays 0 for 20 frames.
- Press row 2/col 1 clean for 5 frames: exactly one key_valid with key_code=4'b1001, key_held=1. Release: key_held falls after 3 NONE frames, no pulse.
- Bounce: toggle row 0/col 3 every 5 cycles for 4 frames, then hold clean: no pulse during bounce. Single pulse with code 4'b0011 at the 3rd clean frame.
- Two keys (row 1/col 0 and row 3/col 2) held 6 frames: no pulse, key_held stays 0. Drop to only row 1/col 0: pulse with code 4'b0100 after 3 frames.
- Roll-over: hold code 4'b0101 accepted, then switch to 4'b1111 without a NONE frame: second pulse with 4'b1111, key_held stays 1.
- Assert rst_n low for 3 cycles during the 2nd debounce frame: all outputs at reset values, col_sel=1110. Press must then re-debounce the full 3 frames.
